// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with leading-zero blank mask.
// Inputs above 9999 are clamped to 9999 and flagged through ovf.
module bin2bcd_seq #(
   parameter int IN_W = 14
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [IN_W-1:0] bin_in,
   output logic            busy,
   output logic            done,
   output logic [15:0]     bcd_out,
   output logic [3:0]      blank_mask,
   output logic            ovf,
   output logic [1:0]      state_dbg
);

   // Handshake: start is accepted on a rising edge only in IDLE or DONE; while busy
   // is high start is ignored and not queued. done pulses for one cycle when the
   // result registers update.

   localparam int CNT_W = $clog2(IN_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [IN_W-1:0]   bin_sh;
   logic [15:0]       scratch;
   logic [15:0]       scratch_adj;
   logic [3:0]        mask_calc;
   logic              ovf_pend;
   logic              accept;
   logic              bin_big;

   assign accept    = start && (state == IDLE || state == DONE);
   assign bin_big   = 16'(bin_in) > 16'd9999;
   assign state_dbg = state;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (cnt == CNT_W'(1)) state_nx = DONE;
         DONE:    state_nx = start ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < 4; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // A digit blanks only when it and every higher digit are zero; digit 0 never blanks.
   always_comb begin
      mask_calc    = 4'b0000;
      mask_calc[3] = (scratch[15:12] == 4'd0);
      mask_calc[2] = mask_calc[3] && (scratch[11:8] == 4'd0);
      mask_calc[1] = mask_calc[2] && (scratch[7:4] == 4'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx == SHIFT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         bin_sh     <= '0;
         scratch    <= '0;
         ovf_pend   <= 1'b0;
         done       <= 1'b0;
         bcd_out    <= 16'h0000;
         blank_mask <= 4'b1110;
         ovf        <= 1'b0;
      end else begin
         done <= (state == DONE);
         // Result registers read scratch before an accept in DONE clears it.
         if (state == DONE) begin
            bcd_out    <= scratch;
            blank_mask <= mask_calc;
            ovf        <= ovf_pend;
         end
         if (accept) begin
            bin_sh   <= bin_big ? IN_W'(14'd9999) : bin_in;
            ovf_pend <= bin_big;
            scratch  <= '0;
            cnt      <= CNT_W'(IN_W);
         end else if (state == SHIFT) begin
            {scratch, bin_sh} <= {scratch_adj, bin_sh} << 1;
            cnt               <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: reset, conversions, blanking, handshake and abort.
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin_in;
   logic        busy;
   logic        done;
   logic [15:0] bcd_out;
   logic [3:0]  blank_mask;
   logic        ovf;
   logic [1:0]  state_dbg;

   int checks;
   int errors;

   bin2bcd_seq #(.IN_W(14)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bin_in     (bin_in),
      .busy       (busy),
      .done       (done),
      .bcd_out    (bcd_out),
      .blank_mask (blank_mask),
      .ovf        (ovf),
      .state_dbg  (state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one start pulse, then count edges until done (or give up after 40).
   task automatic run_conv(input logic [13:0] value, output int lat, output int busy_n);
      int edges;
      bin_in = value;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      edges  = 0;
      busy_n = 0;
      while (done !== 1'b1 && edges < 40) begin
         if (busy === 1'b1) busy_n++;
         tick();
         edges++;
      end
      lat = (done === 1'b1) ? edges : -1;
   endtask

   task automatic test_reset();
      rst    = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      repeat (3) tick();
      checks += 6;
      if (bcd_out !== 16'h0000) begin errors++; $display("FAIL rst_bcd: got %h exp 0000", bcd_out); end
      if (blank_mask !== 4'b1110) begin errors++; $display("FAIL rst_mask: got %b exp 1110", blank_mask); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", ovf); end
      if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state_dbg); end
      rst = 1'b1;
      repeat (3) tick();
      checks += 4;
      if (bcd_out !== 16'h0000) begin errors++; $display("FAIL idle_bcd: got %h exp 0000", bcd_out); end
      if (blank_mask !== 4'b1110) begin errors++; $display("FAIL idle_mask: got %b exp 1110", blank_mask); end
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL idle_done: got %b exp 0", done); end
   endtask

   task automatic test_basic();
      int lat, busy_n;
      run_conv(14'd1234, lat, busy_n);
      checks += 5;
      if (lat != 15) begin errors++; $display("FAIL basic_latency: got %0d exp 15", lat); end
      if (busy_n != 14) begin errors++; $display("FAIL basic_busy_cycles: got %0d exp 14", busy_n); end
      if (bcd_out !== 16'h1234) begin errors++; $display("FAIL basic_bcd: got %h exp 1234", bcd_out); end
      if (blank_mask !== 4'b0000) begin errors++; $display("FAIL basic_mask: got %b exp 0000", blank_mask); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b exp 0", ovf); end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b exp 0", done); end
   endtask

   task automatic test_boundaries();
      logic [13:0] vin  [4] = '{14'd9999, 14'd10000, 14'd16383, 14'd42};
      logic [15:0] vbcd [4] = '{16'h9999, 16'h9999, 16'h9999, 16'h0042};
      logic [3:0]  vmask[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1100};
      logic        vovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int lat, busy_n;
      for (int i = 0; i < 4; i++) begin
         run_conv(vin[i], lat, busy_n);
         checks += 4;
         if (lat != 15) begin errors++; $display("FAIL bound_latency[%0d]: got %0d exp 15", vin[i], lat); end
         if (bcd_out !== vbcd[i]) begin errors++; $display("FAIL bound_bcd[%0d]: got %h exp %h", vin[i], bcd_out, vbcd[i]); end
         if (blank_mask !== vmask[i]) begin errors++; $display("FAIL bound_mask[%0d]: got %b exp %b", vin[i], blank_mask, vmask[i]); end
         if (ovf !== vovf[i]) begin errors++; $display("FAIL bound_ovf[%0d]: got %b exp %b", vin[i], ovf, vovf[i]); end
      end
   endtask

   task automatic test_blanking();
      logic [13:0] vin  [4] = '{14'd0, 14'd7, 14'd100, 14'd1000};
      logic [15:0] vbcd [4] = '{16'h0000, 16'h0007, 16'h0100, 16'h1000};
      logic [3:0]  vmask[4] = '{4'b1110, 4'b1110, 4'b1000, 4'b0000};
      int lat, busy_n;
      for (int i = 0; i < 4; i++) begin
         run_conv(vin[i], lat, busy_n);
         checks += 3;
         if (lat != 15) begin errors++; $display("FAIL blank_latency[%0d]: got %0d exp 15", vin[i], lat); end
         if (bcd_out !== vbcd[i]) begin errors++; $display("FAIL blank_bcd[%0d]: got %h exp %h", vin[i], bcd_out, vbcd[i]); end
         if (blank_mask !== vmask[i]) begin errors++; $display("FAIL blank_mask[%0d]: got %b exp %b", vin[i], blank_mask, vmask[i]); end
      end
      repeat (5) tick();
      checks++;
      if (bcd_out !== 16'h1000) begin errors++; $display("FAIL blank_hold: got %h exp 1000", bcd_out); end
   endtask

   task automatic test_back_to_back();
      int edges;
      int done_at[2];
      logic [15:0] got[2];
      logic [3:0]  gmask[2];
      int n;
      n      = 0;
      bin_in = 14'd2468;
      start  = 1'b1;
      tick();
      bin_in = 14'd305;
      edges  = 0;
      while (n < 2 && edges < 60) begin
         tick();
         edges++;
         if (done === 1'b1) begin
            done_at[n] = edges;
            got[n]     = bcd_out;
            gmask[n]   = blank_mask;
            n++;
            if (n == 1) start = 1'b0;
         end
      end
      checks += 7;
      if (n != 2) begin errors++; $display("FAIL b2b_done_count: got %0d exp 2", n); end
      if (done_at[0] != 15) begin errors++; $display("FAIL b2b_first_at: got %0d exp 15", done_at[0]); end
      if (done_at[1] != 30) begin errors++; $display("FAIL b2b_second_at: got %0d exp 30", done_at[1]); end
      if (got[0] !== 16'h2468) begin errors++; $display("FAIL b2b_first_bcd: got %h exp 2468", got[0]); end
      if (got[1] !== 16'h0305) begin errors++; $display("FAIL b2b_second_bcd: got %h exp 0305", got[1]); end
      if (gmask[1] !== 4'b1000) begin errors++; $display("FAIL b2b_second_mask: got %b exp 1000", gmask[1]); end
      tick();
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop_busy: got %b exp 0", busy); end
   endtask

   task automatic test_ignore();
      int edges;
      bin_in = 14'd4321;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (4) tick();
      checks += 2;
      if (bcd_out !== 16'h0305) begin errors++; $display("FAIL ign_no_partial: got %h exp 0305", bcd_out); end
      if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy_mid: got %b exp 1", busy); end
      start  = 1'b1;
      bin_in = 14'd8765;
      tick();
      start  = 1'b0;
      bin_in = 14'd1111;
      edges  = 5;
      while (done !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
      checks += 3;
      if (edges != 15) begin errors++; $display("FAIL ign_latency: got %0d exp 15", edges); end
      if (bcd_out !== 16'h4321) begin errors++; $display("FAIL ign_bcd: got %h exp 4321", bcd_out); end
      if (blank_mask !== 4'b0000) begin errors++; $display("FAIL ign_mask: got %b exp 0000", blank_mask); end
      repeat (3) tick();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue_busy: got %b exp 0", busy); end
      if (bcd_out !== 16'h4321) begin errors++; $display("FAIL ign_hold: got %h exp 4321", bcd_out); end
   endtask

   task automatic test_abort();
      int lat, busy_n;
      int done_seen;
      bin_in = 14'd5678;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (7) tick();
      rst = 1'b0;
      #1;
      checks += 5;
      if (bcd_out !== 16'h0000) begin errors++; $display("FAIL abort_bcd: got %h exp 0000", bcd_out); end
      if (blank_mask !== 4'b1110) begin errors++; $display("FAIL abort_mask: got %b exp 1110", blank_mask); end
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b exp 0", done); end
      if (state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d exp 0", state_dbg); end
      done_seen = 0;
      repeat (10) begin
         tick();
         if (done === 1'b1 || bcd_out !== 16'h0000) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin errors++; $display("FAIL abort_quiet: got %0d exp 0", done_seen); end
      rst = 1'b1;
      run_conv(14'd5678, lat, busy_n);
      checks += 4;
      if (lat != 15) begin errors++; $display("FAIL abort_rerun_latency: got %0d exp 15", lat); end
      if (bcd_out !== 16'h5678) begin errors++; $display("FAIL abort_rerun_bcd: got %h exp 5678", bcd_out); end
      if (blank_mask !== 4'b0000) begin errors++; $display("FAIL abort_rerun_mask: got %b exp 0000", blank_mask); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL abort_rerun_ovf: got %b exp 0", ovf); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_boundaries();
      test_blanking();
      test_back_to_back();
      test_ignore();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter IN_W, default 14: binary input width; legal range 4..14.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: conversion request, sampled on clk.
REQ-005 SHALL have port bin_in, input, IN_W: unsigned binary value, sampled when start is accepted.
REQ-006 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when bcd_out is updated.
REQ-008 SHALL have port bcd_out, output, 16: four packed BCD digits, digit0 = [3:0], drives the display D_in.
REQ-009 SHALL have port blank_mask, output, 4: bit i=1 means digit i is a leading zero to blank.
REQ-010 SHALL have port ovf, output, 1: last converted input exceeded 9999.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; SHIFT uses a shift counter of ceil(log2(IN_W+1)) bits.
REQ-012 start SHALL be accepted only in IDLE or DONE; start in SHIFT SHALL be ignored with no queuing.
REQ-013 On accept edge E0: latch bin_in; if bin_in > 9999, substitute 9999 and set internal ovf_pend, else clear ovf_pend; clear 16-bit BCD scratch; load counter = IN_W; go to SHIFT.
REQ-014 In SHIFT, at each edge E1..E(IN_W): add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one; decrement counter; after the IN_W-th shift, go to DONE.
REQ-015 At edge E(IN_W+1): register scratch into bcd_out, ovf_pend into ovf, and the computed blank_mask; set done=1; state = DONE for exactly one cycle.
REQ-016 Latency SHALL be fixed at IN_W+1 edges from accept to done high, independent of value and of ovf.
REQ-017 From DONE, the next edge SHALL go to IDLE, or to SHIFT if start is high. This gives back-to-back throughput of one conversion per IN_W+1 cycles.
REQ-018 busy SHALL equal (state == SHIFT), registered.
REQ-019 bcd_out, blank_mask, and ovf SHALL hold their values between done pulses and SHALL never show partial results.
REQ-020 blank_mask[0] SHALL always be 0.
REQ-021 blank_mask[i] for i=1..3 SHALL be 1 iff digit i and all higher digits are zero.
REQ-022 ovf SHALL reflect only the most recent completed conversion.
REQ-023 bin_in changes after E0 SHALL NOT affect the conversion in progress.

Reset
REQ-024 While rst=0, regardless of clk, outputs SHALL be: state IDLE, busy=0, done=0, bcd_out=16'h0000, blank_mask=4'b1110, ovf=0; counter and scratch cleared.
REQ-025 Reset asserted mid-conversion SHALL abort it: no done pulse and no bcd_out update.
REQ-026 After rst deasserts, start SHALL be accepted on the first rising edge.

Verification
REQ-027 Reset check: hold rst=0 -> bcd_out=0x0000, blank_mask=1110, busy=0, done=0, ovf=0; after release, idle outputs remain stable.
REQ-028 Basic conversion and latency (IN_W=14): bin_in=1234, start one cycle -> busy high 14 cycles, done at E15, bcd_out=0x1234, mask=0000, ovf=0.
REQ-029 Boundaries:
- 9999 -> 0x9999, ovf=0
- 10000 -> 0x9999, ovf=1
- 16383 -> 0x9999, ovf=1
- then 42 -> 0x0042, ovf=0, mask=1100
REQ-030 Blanking:
- 0 -> 0x0000, mask 1110
- 7 -> 0x0007, mask 1110
- 100 -> 0x0100, mask 1000
- 1000 -> 0x1000, mask 0000
REQ-031 Handshake:
- start held high continuously -> conversions back-to-back every 15 cycles.
- start pulses and bin_in changes during SHIFT -> ignored; result matches the value latched at E0.
REQ-032 Abort: rst=0 at E7 of a conversion of 5678 -> outputs return to reset values asynchronously, no done; a subsequent conversion of 5678 yields 0x5678.
